// File: rtl/wide_add_seq.sv
// Multi-precision adder: one shared 32-bit adder walks WORDS words LSW first, carry chained through a register.
// Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN (adds the `sub` port).

module add32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);
   assign {co, s} = {1'b0, x} + {1'b0, y} + {32'd0, ci};
endmodule

// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// i_ready/o_valid come straight from the state register, so neither depends on any input.
module wide_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [32*WORDS-1:0]  a,
   input  logic [32*WORDS-1:0]  b,
   input  logic                 c_in,
`ifdef WIDE_ADD_SUB_EN
   input  logic                 sub,
`endif
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [32*WORDS-1:0]  sum,
   output logic                 c_out,
   output logic [1:0]           state_dbg
);
   localparam int W  = 32 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          carry_q;
   logic [IW-1:0] idx;
   logic [31:0]   add_x;
   logic [31:0]   add_y;
   logic [31:0]   add_s;
   logic          add_co;
   logic          accept;

   assign accept    = (state == IDLE) && i_valid;
   assign i_ready   = (state == IDLE);
   assign o_valid   = (state == DONE);
   assign state_dbg = state;

`ifdef WIDE_ADD_SUB_EN
   logic sub_q;
   // Subtraction is a + ~b + 1: invert every B word and seed the carry with 1.
   assign add_y = b_q[32*idx +: 32] ^ {32{sub_q}};
`else
   assign add_y = b_q[32*idx +: 32];
`endif
   assign add_x = a_q[32*idx +: 32];

   add32 u_add32 (
      .x  (add_x),
      .y  (add_y),
      .ci (carry_q),
      .s  (add_s),
      .co (add_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_valid) state_nx = RUN;
         RUN:     if (idx == LAST) state_nx = DONE;
         DONE:    if (o_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         c_out   <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         idx     <= '0;
         sum     <= '0;
         c_out   <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
         sub_q   <= sub;
         carry_q <= sub ? 1'b1 : c_in;
`else
         carry_q <= c_in;
`endif
      end else if (state == RUN) begin
         sum[32*idx +: 32] <= add_s;
         carry_q           <= add_co;
         if (idx == LAST) begin
            c_out <= add_co;
            idx   <= '0;
         end else begin
            idx   <= idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed vectors on WORDS=4 and WORDS=1 instances plus random sums.
// Subtract vectors are included when WIDE_ADD_SUB_EN is defined.

module tb_wide_add_seq;
   logic         clk;
   logic         rst_n;

   logic         i_valid4, i_ready4, o_valid4, o_ready4, c_in4, c_out4;
   logic [127:0] a4, b4, sum4;
   logic [1:0]   st4;
`ifdef WIDE_ADD_SUB_EN
   logic         sub4;
   logic         sub1;
`endif

   logic         i_valid1, i_ready1, o_valid1, o_ready1, c_in1, c_out1;
   logic [31:0]  a1, b1, sum1;
   logic [1:0]   st1;

   int           n_checks;
   int           n_errors;
   logic [128:0] exp_q[$];
   logic [32:0]  exp1_q[$];

   wide_add_seq #(.WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid4), .i_ready(i_ready4),
      .a(a4), .b(b4), .c_in(c_in4),
`ifdef WIDE_ADD_SUB_EN
      .sub(sub4),
`endif
      .o_valid(o_valid4), .o_ready(o_ready4), .sum(sum4), .c_out(c_out4),
      .state_dbg(st4)
   );

   wide_add_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid1), .i_ready(i_ready1),
      .a(a1), .b(b1), .c_in(c_in1),
`ifdef WIDE_ADD_SUB_EN
      .sub(sub1),
`endif
      .o_valid(o_valid1), .o_ready(o_ready1), .sum(sum1), .c_out(c_out1),
      .state_dbg(st1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks, WORDS=4 instance
   task automatic start4(input logic [127:0] av, input logic [127:0] bv, input logic ci);
      int n = 0;
      while (!i_ready4 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check_eq("ready4_wait", 256'(i_ready4), 256'(1));
      a4 = av; b4 = bv; c_in4 = ci; i_valid4 = 1'b1;
      @(posedge clk); #1;
      i_valid4 = 1'b0;
      a4 = {$urandom, $urandom, $urandom, $urandom};
      b4 = {$urandom, $urandom, $urandom, $urandom};
      c_in4 = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done4(output int lat);
      lat = 0;
      while (!o_valid4 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic take4;
      o_ready4 = 1'b1;
      @(posedge clk); #1;
      o_ready4 = 1'b0;
   endtask

   // driver tasks, WORDS=1 instance
   task automatic start1(input logic [31:0] av, input logic [31:0] bv, input logic ci);
      int n = 0;
      while (!i_ready1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check_eq("ready1_wait", 256'(i_ready1), 256'(1));
      a1 = av; b1 = bv; c_in1 = ci; i_valid1 = 1'b1;
      @(posedge clk); #1;
      i_valid1 = 1'b0;
      a1 = $urandom; b1 = $urandom;
   endtask

   task automatic wait_done1(output int lat);
      lat = 0;
      while (!o_valid1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic take1;
      o_ready1 = 1'b1;
      @(posedge clk); #1;
      o_ready1 = 1'b0;
   endtask

   initial begin
      int           lat;
      logic [127:0] av, bv, hold_sum;
      logic         ci, hold_c, seen;
      logic [31:0]  a1v, b1v;

      n_checks = 0; n_errors = 0;
      rst_n = 1'b0;
      i_valid4 = 1'b0; o_ready4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0;
      i_valid1 = 1'b0; o_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub4 = 1'b0; sub1 = 1'b0;
`endif
      #12;
      check_eq("rst_i_ready", 256'(i_ready4), 256'(1));
      check_eq("rst_o_valid", 256'(o_valid4), 256'(0));
      check_eq("rst_sum", 256'(sum4), 256'(0));
      check_eq("rst_c_out", 256'(c_out4), 256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // full carry chain across all four words, latency exactly WORDS
      start4({128{1'b1}}, 128'd1, 1'b0);
      wait_done4(lat);
      check_eq("chain_lat", 256'(lat), 256'(4));
      check_eq("chain_sum", 256'(sum4), 256'(0));
      check_eq("chain_c_out", 256'(c_out4), 256'(1));
      take4;

      // carry out of word 0 into word 1
      start4(128'hFFFF_FFFF, 128'd1, 1'b1);
      wait_done4(lat);
      check_eq("xword_sum", 256'(sum4), 256'h1_0000_0001);
      check_eq("xword_c_out", 256'(c_out4), 256'(0));
      take4;

      // backpressure: DONE holds with o_ready low, i_valid pulses ignored
      start4(128'h8000_0000_0000_0000_0000_0000_0000_0003, 128'h8000_0000_0000_0000_0000_0000_0000_0005, 1'b0);
      wait_done4(lat);
      check_eq("bp_sum0", 256'(sum4), 256'h8);
      check_eq("bp_c0", 256'(c_out4), 256'(1));
      hold_sum = sum4; hold_c = c_out4;
      for (int i = 0; i < 10; i++) begin
         i_valid4 = i[0];
         a4 = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check_eq("bp_sum", 256'(sum4), 256'(hold_sum));
         check_eq("bp_c_out", 256'(c_out4), 256'(hold_c));
         check_eq("bp_o_valid", 256'(o_valid4), 256'(1));
         check_eq("bp_i_ready", 256'(i_ready4), 256'(0));
      end
      i_valid4 = 1'b0;
      take4;
      check_eq("bp_ready_after", 256'(i_ready4), 256'(1));
      check_eq("bp_valid_after", 256'(o_valid4), 256'(0));
      check_eq("bp_sum_kept", 256'(sum4), 256'(hold_sum));

      // reset after two RUN cycles aborts the operation
      start4({4{32'h1234_5678}}, {4{32'h1111_1111}}, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("abort_partial", 256'(sum4 != 128'd0), 256'(1));
      rst_n = 1'b0;
      #1;
      check_eq("abort_i_ready", 256'(i_ready4), 256'(1));
      check_eq("abort_o_valid", 256'(o_valid4), 256'(0));
      check_eq("abort_sum", 256'(sum4), 256'(0));
      check_eq("abort_c_out", 256'(c_out4), 256'(0));
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (o_valid4) seen = 1'b1;
      end
      check_eq("abort_no_valid", 256'(seen), 256'(0));
      start4(128'd5, 128'd7, 1'b0);
      wait_done4(lat);
      check_eq("post_abort_sum", 256'(sum4), 256'd12);
      check_eq("post_abort_c", 256'(c_out4), 256'(0));
      take4;

`ifdef WIDE_ADD_SUB_EN
      sub4 = 1'b1;
      start4(128'd0, 128'd1, 1'b0);
      sub4 = 1'b0;
      wait_done4(lat);
      check_eq("sub_borrow_sum", 256'(sum4), 256'({128{1'b1}}));
      check_eq("sub_borrow_c", 256'(c_out4), 256'(0));
      take4;
      sub4 = 1'b1;
      start4(128'h1234, 128'h1234, 1'b0);
      sub4 = 1'b0;
      wait_done4(lat);
      check_eq("sub_eq_sum", 256'(sum4), 256'(0));
      check_eq("sub_eq_c", 256'(c_out4), 256'(1));
      take4;
`endif

      // WORDS=1: single RUN cycle
      start1(32'hFFFF_FFFF, 32'd1, 1'b1);
      wait_done1(lat);
      check_eq("w1_lat", 256'(lat), 256'(1));
      check_eq("w1_sum", 256'(sum1), 256'(1));
      check_eq("w1_c_out", 256'(c_out1), 256'(1));
      take1;

      // random scoreboard, WORDS=4
      for (int i = 0; i < 200; i++) begin
         av = {$urandom, $urandom, $urandom, $urandom};
         bv = {$urandom, $urandom, $urandom, $urandom};
         ci = 1'($urandom_range(0, 1));
         exp_q.push_back({1'b0, av} + {1'b0, bv} + {128'd0, ci});
         start4(av, bv, ci);
         wait_done4(lat);
         check_eq("rand4_lat", 256'(lat), 256'(4));
         check_eq("rand4", 256'({c_out4, sum4}), 256'(exp_q.pop_front()));
         take4;
      end

      // random scoreboard, WORDS=1
      for (int i = 0; i < 200; i++) begin
         a1v = $urandom;
         b1v = $urandom;
         ci = 1'($urandom_range(0, 1));
         exp1_q.push_back({1'b0, a1v} + {1'b0, b1v} + {32'd0, ci});
         start1(a1v, b1v, ci);
         wait_done1(lat);
         check_eq("rand1_lat", 256'(lat), 256'(1));
         check_eq("rand1", 256'({c_out1, sum1}), 256'(exp1_q.pop_front()));
         take1;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-precision adder controller that sequences one shared `add32` instance over a WORDS×32-bit operand pair, least-significant word first, chaining the carry through a register between words. It sits between a requester issuing wide additions over a valid/ready handshake and a consumer taking the registered result. The block trades area for latency: one 32-bit ripple adder serves arbitrarily wide operands.

## Interface
- `WORDS`, 4, number of 32-bit words per operand; legal range 1..16; operand width W = 32*WORDS.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  request valid.
- `i_ready`  out  1  block can accept a request; high only in IDLE.
- `a`  in  W  operand A; sampled on accept.
- `b`  in  W  operand B; sampled on accept.
- `c_in`  in  1  carry into word 0; sampled on accept.
- `sub`  in  1  present only with `WIDE_ADD_SUB_EN`; sampled on accept.
- `o_valid`  out  1  result valid; high only in DONE.
- `o_ready`  in  1  consumer takes result.
- `sum`  out  W  registered result.
- `c_out`  out  1  carry out of the top word.

## Operation
- States: IDLE, RUN, DONE. Word counter `idx` is 0..WORDS-1, width $clog2(WORDS) with a minimum of 1 bit.
- IDLE: `i_ready`=1. When `i_valid` is high at a rising edge, the block latches `a`, `b`, and `c_in` into operand registers and sets the carry register to `c_in`. It clears `sum`, sets `idx`=0 and moves to RUN.
- RUN: the shared `add32` is driven with A word `idx`, B word `idx`, and the carry register.
  - Each edge writes the adder result into `sum` word `idx` and the adder carry-out into the carry register.
  - `idx` then increments.
  - On the edge where `idx`=WORDS-1 the block enters DONE and `c_out` takes the final carry.
- DONE: `o_valid`=1. `sum` and `c_out` hold stable.
  - When `o_ready` is high at a rising edge, the block moves to IDLE.
  - `sum` and `c_out` keep their values until the next accept.
- Arithmetic: `{c_out, sum}` = `a` + `b` + `c_in`, computed mod 2^(W+1).
- Inputs other than `o_ready` are ignored outside IDLE. `a`, `b`, and `c_in` may change freely after accept.
- `i_valid` may drop without acceptance; there is no request-side hold requirement.
- Exactly one `add32` instance; no other adder exists in the datapath.

## Timing
- Reset (async assert, sync release by the environment):
  - State goes to IDLE. `i_ready`=1 and `o_valid`=0.
  - `sum`=0, `c_out`=0, `idx`=0, carry register 0.
- Reset asserted in RUN or DONE aborts the operation immediately; the result is lost. The first edge after release may accept a new request.
- Latency: accept at edge E0, then `o_valid` rises after edge E_WORDS, i.e. exactly WORDS cycles later.
- WORDS=1: a single RUN cycle, so latency is 1.
- The handshake in DONE completes at edge Ek. `i_ready` rises after Ek, so the next accept is no earlier than Ek+1.
- Best-case throughput is one operation per WORDS+2 cycles.
- `o_ready` held low stalls DONE indefinitely with outputs constant.
- `i_ready` and `o_valid` are decoded directly from state registers, with no combinational path from inputs.

## Configuration
- `WIDE_ADD_SUB_EN` defined:
  - Adds the `sub` port and a latched sub flag.
  - When the flag is set, every B word is bitwise inverted before entering `add32`, and the carry register is initialised to 1. `c_in` is ignored.
  - Result: `sum` = `a` − `b` mod 2^W; `c_out` = 1 means no borrow.
  - With `sub`=0, behaviour is identical to the undefined build.
- Undefined: no `sub` port, no inverter logic; add-only as above.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation. Required: `i_ready`=1, `o_valid`=0, `sum`=0, `c_out`=0.
- Full carry chain, WORDS=4: `a`=2^128−1, `b`=1, `c_in`=0. Required: `sum`=0 and `c_out`=1, with `o_valid` rising exactly 4 cycles after accept.
- Cross-word carry: `a`=0xFFFFFFFF, `b`=1, `c_in`=1. Required: `sum`=0x1_00000001, `c_out`=0.
- Backpressure: with `o_ready`=0 for 10 cycles, `sum`, `c_out` and `o_valid` hold stable and `i_ready`=0. Pulses on `i_valid` are ignored.
  - After `o_ready`=1 for one edge, `i_ready`=1 on the next cycle.
- Reset after 2 RUN cycles: `o_valid` never asserts, all outputs return to reset values. The following operation `a`=5, `b`=7 yields `sum`=12.
- Random check: 200 random `a`, `b`, `c_in` operations for WORDS=1 and WORDS=4, compared against `a`+`b`+`c_in`.
  - With `WIDE_ADD_SUB_EN`: `sub`=1, `a`=0, `b`=1 gives `sum`=all ones and `c_out`=0.
  - With `WIDE_ADD_SUB_EN`: `sub`=1, `a`=`b`=0x1234 gives `sum`=0 and `c_out`=1.
